// File: rtl/csa_accum_ctrl.sv
// Carry-save frame accumulator: sums up to 16 unsigned operands per frame, then ripples the carry out.
// Optional CSA_ACCUM_PERF_EN adds res_cycles, the RESOLVE duration of the last frame.
module csa_accum_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N+3:0] out_data,
  output logic [4:0]   out_count,
  output logic         out_trunc
`ifdef CSA_ACCUM_PERF_EN
  ,
  output logic [4:0]   res_cycles
`endif
);
  localparam int unsigned W       = N + 4;
  localparam int unsigned MAX_OPS = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_t;

  state_t       state_q;
  logic [W-1:0] s_q, c_q, s_d, c_d, x;
  logic [4:0]   cnt_q, cnt_d;
  logic [W-1:0] out_data_q;
  logic [4:0]   out_count_q;
  logic         out_trunc_q;
  logic         out_valid_q;
  logic         xfer, done;
`ifdef CSA_ACCUM_PERF_EN
  logic [4:0]   res_cnt_q;
  logic [4:0]   res_cycles_q;
`endif

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_trunc = out_trunc_q;
`ifdef CSA_ACCUM_PERF_EN
  assign res_cycles = res_cycles_q;
`endif

  // s_d/c_d hold the load, the 3:2 compression or the carry-ripple step depending on state
  always_comb begin
    x     = W'(in_data);
    xfer  = in_valid && in_ready;
    s_d   = s_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      s_d   = x;
      c_d   = '0;
      cnt_d = 5'd1;
    end else if (state_q == ACCUM) begin
      s_d   = s_q ^ c_q ^ x;
      c_d   = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
      cnt_d = cnt_q + 5'd1;
    end else begin
      s_d   = s_q ^ c_q;
      c_d   = (s_q & c_q) << 1;
    end
    done = in_last || (cnt_d == 5'(MAX_OPS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
`ifdef CSA_ACCUM_PERF_EN
      res_cnt_q    <= '0;
      res_cycles_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (xfer) begin
            s_q   <= s_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
            if (done) begin
              state_q     <= RESOLVE;
              out_trunc_q <= !in_last;
`ifdef CSA_ACCUM_PERF_EN
              res_cnt_q   <= '0;
`endif
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        RESOLVE: begin
          if (c_q == '0) begin
            state_q     <= OUTPUT;
            out_valid_q <= 1'b1;
            out_data_q  <= s_q;
            out_count_q <= cnt_q;
`ifdef CSA_ACCUM_PERF_EN
            res_cycles_q <= res_cnt_q + 5'd1;
`endif
          end else begin
            s_q <= s_d;
            c_q <= c_d;
`ifdef CSA_ACCUM_PERF_EN
            res_cnt_q <= res_cnt_q + 5'd1;
`endif
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl: table vectors, directed corner sequences, random frames vs. a sum model.
module tb_csa_accum_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned W = N + 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [4:0]   out_count;
  logic         out_trunc;
`ifdef CSA_ACCUM_PERF_EN
  logic [4:0]   res_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  csa_accum_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_trunc (out_trunc)
`ifdef CSA_ACCUM_PERF_EN
    ,
    .res_cycles(res_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [N-1:0] d, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 60) begin
      tick();
      guard++;
    end
    if (guard >= 60) chk("in_ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input int hold, output logic [W-1:0] d, output logic [4:0] c,
                            output logic t, output int lat);
    out_ready = (hold == 0);
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    d = out_data;
    c = out_count;
    t = out_trunc;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(d));
      chk("hold_count", 32'(out_count), 32'(c));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    int unsigned n;
    logic [63:0] ops;
    logic        last;
    int unsigned sum;
    int unsigned cnt;
    logic        trunc;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] d;
    logic [4:0]   c;
    logic         t;
    int           lat;
    logic [63:0]  ops;
    logic [W-1:0] got[$];

    vecs[0] = '{3,  64'h0000_0000_0000_0412, 1'b1, 7,   3,  1'b0, 0};
    vecs[1] = '{1,  64'h0000_0000_0000_000F, 1'b1, 15,  1,  1'b0, 0};
    vecs[2] = '{16, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 240, 16, 1'b1, 10};
    vecs[3] = '{1,  64'h0000_0000_0000_0000, 1'b1, 0,   1,  1'b0, 2};
    vecs[4] = '{16, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 240, 16, 1'b0, 0};
    vecs[5] = '{5,  64'h0000_0000_0005_4321, 1'b1, 15,  5,  1'b0, 3};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_trunc", 32'(out_trunc), 32'd0);

    for (int v = 0; v < 6; v++) begin
      ops = vecs[v].ops;
      for (int unsigned i = 0; i < vecs[v].n; i++)
        send_op(ops[4*i +: 4], vecs[v].last && (i == vecs[v].n - 1));
      chk("tbl_in_ready_after_last", 32'(in_ready), 32'd0);
      get_result(vecs[v].hold, d, c, t, lat);
      chk("tbl_data", 32'(d), vecs[v].sum);
      chk("tbl_count", 32'(c), vecs[v].cnt);
      chk("tbl_trunc", 32'(t), 32'(vecs[v].trunc));
      chk("tbl_resolve_min", 32'(lat >= 1), 32'd1);
      chk("tbl_resolve_max", 32'(lat <= int'(W) + 1), 32'd1);
      if (vecs[v].n == 1) begin
        chk("single_resolve_1cyc", 32'(lat), 32'd1);
`ifdef CSA_ACCUM_PERF_EN
        chk("single_res_cycles", 32'(res_cycles), 32'd1);
`endif
      end
    end

    // Two frames streamed with the consumer always ready: both results, in order
    fork
      begin
        send_op(4'd3, 1'b0); send_op(4'd2, 1'b0); send_op(4'd0, 1'b1);
        send_op(4'd13, 1'b0); send_op(4'd9, 1'b0); send_op(4'd3, 1'b1);
      end
      begin
        out_ready = 1'b1;
        for (int k = 0; k < 200 && got.size() < 2; k++) begin
          tick();
          if (out_valid) got.push_back(out_data);
        end
        tick();
        out_ready = 1'b0;
      end
    join
    chk("b2b_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("b2b_first", 32'(got[0]), 32'd5);
      chk("b2b_second", 32'(got[1]), 32'd25);
    end

    // Reset mid-frame discards it
    send_op(4'd7, 1'b0);
    send_op(4'd6, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    send_op(4'd1, 1'b0);
    send_op(4'd1, 1'b1);
    get_result(0, d, c, t, lat);
    chk("midrst_new_data", 32'(d), 32'd2);
    chk("midrst_new_count", 32'(c), 32'd2);

    // Random frames vs. plain-sum model
    for (int f = 0; f < 40; f++) begin
      int unsigned len, sum;
      logic trunc;
      len   = $urandom_range(1, 16);
      trunc = (len == 16) && ($urandom_range(0, 1) == 1);
      sum   = 0;
      for (int unsigned i = 0; i < len; i++) begin
        logic [N-1:0] op;
        op = N'($urandom_range(0, 15));
        sum += op;
        send_op(op, !trunc && (i == len - 1));
        repeat ($urandom_range(0, 2)) tick();
      end
      get_result($urandom_range(0, 3), d, c, t, lat);
      chk("rnd_data", 32'(d), sum);
      chk("rnd_count", 32'(c), len);
      chk("rnd_trunc", 32'(t), 32'(trunc));
      chk("rnd_resolve_max", 32'(lat <= int'(W) + 1 + 2), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
